formula_sweep_driver: RTL and testbench

- Upstream stimulus stage for the combinational fixpoint checker (one 49-bit assignment in, one-bit o_1 verdict out).
- Enumerates every assignment of a selected subset of the variables, with the remaining variables held at a fixed base pattern, and issues one vector per cycle to the checker.
- Collects the verdicts, which return in order after a fixed latency, and stops at the first vector whose verdict is 0.
- Reports PASS, or FAIL plus the counterexample, through a valid/ready result port.

---
 rtl/formula_sweep_pkg.sv | 20 ++
 rtl/formula_sweep_driver_bit_deposit.sv | 25 ++
 rtl/formula_sweep_driver.sv | 138 +++++++++++++
 tb/tb_formula_sweep_driver.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/formula_sweep_pkg.sv
// Shared types for the formula sweep driver: FSM states, default widths, result record.
package formula_sweep_pkg;

  localparam int unsigned NumVars = 49;
  localparam int unsigned CntW    = NumVars + 1;

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StDrain,
    StResult
  } state_e;

  typedef struct packed {
    logic                fail;
    logic [NumVars-1:0]  vec;
    logic [CntW-1:0]     count;
  } result_t;

endpackage

// File: rtl/formula_sweep_driver_bit_deposit.sv
// Scatters the low bits of k into the set positions of mask, LSB first; other bits are 0.
module bit_deposit #(
  parameter int unsigned W = 49
) (
  input  logic [W-1:0] k_i,
  input  logic [W-1:0] mask_i,
  output logic [W-1:0] dep_o
);

  localparam int unsigned IdxW = $clog2(W + 1);

  logic [IdxW-1:0] idx;

  always_comb begin
    dep_o = '0;
    idx   = '0;
    for (int i = 0; i < W; i++) begin
      if (mask_i[i]) begin
        dep_o[i] = k_i[idx];
        idx      = idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/formula_sweep_driver.sv
// Enumerates all assignments of the masked variables, feeds them to the fixpoint checker
// one per cycle and reports PASS or the first counterexample over a valid/ready port.
module formula_sweep_driver
  import formula_sweep_pkg::*;
#(
  parameter int unsigned NUM_VARS  = NumVars,
  parameter int unsigned CHECK_LAT = 1,
  parameter int unsigned CNT_W     = NUM_VARS + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [NUM_VARS-1:0] base_i,
  input  logic [NUM_VARS-1:0] mask_i,
  output logic [NUM_VARS-1:0] chk_vec_o,
  output logic                chk_valid_o,
  input  logic                chk_res_i,
  output logic                busy_o,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic                res_fail_o,
  output logic [NUM_VARS-1:0] res_vec_o,
  output logic [CNT_W-1:0]    res_count_o
);

  // Pipe storage needs at least one stage even when the checker is purely combinational.
  localparam int unsigned PD = (CHECK_LAT > 0) ? CHECK_LAT : 1;

  state_e                       state_q, state_d;
  logic [NUM_VARS-1:0]          base_q, base_d, mask_q, mask_d;
  logic [CNT_W-1:0]             k_q, k_d;
  result_t                      res_q, res_d;
  logic [PD-1:0]                pv_q, pv_d;
  logic [PD-1:0][NUM_VARS-1:0]  pvec_q, pvec_d;

  logic [NUM_VARS-1:0] dep, launch_vec, ret_vec;
  logic                launch, ret_v, fail_hit;

  bit_deposit #(
    .W (NUM_VARS)
  ) u_bit_deposit (
    .k_i    (k_q[NUM_VARS-1:0]),
    .mask_i (mask_q),
    .dep_o  (dep)
  );

  always_comb begin
    launch     = (state_q == StSweep);
    launch_vec = (base_q & ~mask_q) | dep;

    pv_d[0]   = launch;
    pvec_d[0] = launch_vec;
    for (int i = 1; i < PD; i++) begin
      pv_d[i]   = pv_q[i-1];
      pvec_d[i] = pvec_q[i-1];
    end

    if (CHECK_LAT == 0) begin
      ret_v   = launch;
      ret_vec = launch_vec;
      pv_d    = '0;
    end else begin
      ret_v   = pv_q[PD-1];
      ret_vec = pvec_q[PD-1];
    end
    fail_hit = ret_v & ~chk_res_i;

    state_d = state_q;
    base_d  = base_q;
    mask_d  = mask_q;
    k_d     = k_q;
    res_d   = res_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          base_d  = base_i;
          mask_d  = mask_i;
          k_d     = '0;
          res_d   = '0;
          state_d = StSweep;
        end
      end
      StSweep, StDrain: begin
        if (ret_v) res_d.count = res_q.count + 1'b1;
        // Priority: abort, then failing verdict, then normal sweep/drain progress.
        if (abort_i) begin
          pv_d    = '0;
          state_d = StIdle;
        end else if (fail_hit) begin
          res_d.fail = 1'b1;
          res_d.vec  = ret_vec;
          pv_d       = '0;
          state_d    = StResult;
        end else if (state_q == StSweep) begin
          k_d = k_q + 1'b1;
          if (dep == mask_q) state_d = (|pv_d) ? StDrain : StResult;
        end else if (!(|pv_d)) begin
          state_d = StResult;
        end
      end
      StResult: begin
        if (res_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      base_q  <= '0;
      mask_q  <= '0;
      k_q     <= '0;
      res_q   <= '0;
      pv_q    <= '0;
      pvec_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      mask_q  <= mask_d;
      k_q     <= k_d;
      res_q   <= res_d;
      pv_q    <= pv_d;
      pvec_q  <= pvec_d;
    end
  end

  assign chk_valid_o = launch;
  assign chk_vec_o   = launch ? launch_vec : '0;
  assign busy_o      = (state_q != StIdle);
  assign res_valid_o = (state_q == StResult);
  assign res_fail_o  = res_q.fail;
  assign res_vec_o   = res_q.vec;
  assign res_count_o = res_q.count;

endmodule

// File: tb/tb_formula_sweep_driver.sv
// Randomized and directed bench for formula_sweep_driver against a set-enumeration model.
module tb_formula_sweep_driver;

  localparam int NV = 49;
  localparam int CW = 50;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic          res_ready_i = 1'b0;
  logic [NV-1:0] base_i = '0;
  logic [NV-1:0] mask_i = '0;
  logic [NV-1:0] chk_vec_o, res_vec_o;
  logic          chk_valid_o, chk_res_i, busy_o, res_valid_o, res_fail_o;
  logic [CW-1:0] res_count_o;

  formula_sweep_driver #(
    .NUM_VARS  (NV),
    .CHECK_LAT (1),
    .CNT_W     (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .base_i      (base_i),
    .mask_i      (mask_i),
    .chk_vec_o   (chk_vec_o),
    .chk_valid_o (chk_valid_o),
    .chk_res_i   (chk_res_i),
    .busy_o      (busy_o),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_fail_o  (res_fail_o),
    .res_vec_o   (res_vec_o),
    .res_count_o (res_count_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Checker model: verdict is 0 only for vectors listed in bad_q, one cycle late.
  logic [NV-1:0] bad_q[$];
  logic          del_v, del_ok;

  function automatic logic checker_ok(input logic [NV-1:0] v);
    foreach (bad_q[i]) if (bad_q[i] == v) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      del_v  <= 1'b0;
      del_ok <= 1'b1;
    end else begin
      del_v  <= chk_valid_o;
      del_ok <= checker_ok(chk_vec_o);
    end
  end
  assign chk_res_i = !del_v || del_ok;

  // Reference: launches are all vectors agreeing with base off-mask, in ascending order.
  logic [NV-1:0] exp_q[$];
  int            lidx = 0;
  bit            mon_en = 1'b0;
  logic          e_fail;
  logic [NV-1:0] e_vec;
  logic [CW-1:0] e_count;
  int            e_launch;
  logic          got_fail;
  logic [NV-1:0] got_vec;
  logic [CW-1:0] got_count;

  task automatic build_model(input logic [NV-1:0] base, input logic [NV-1:0] mask);
    logic [NV-1:0] sub;
    int f, n;
    exp_q.delete();
    sub = '0;
    do begin
      exp_q.push_back((base & ~mask) | sub);
      sub = (sub - mask) & mask;
    end while (sub != '0);
    f = -1;
    foreach (exp_q[i]) if (f < 0 && !checker_ok(exp_q[i])) f = i;
    n        = exp_q.size();
    e_fail   = (f >= 0);
    e_vec    = (f >= 0) ? exp_q[f] : '0;
    e_count  = (f >= 0) ? CW'(f + 1) : CW'(n);
    e_launch = (f < 0) ? n : ((f + 2 < n) ? f + 2 : n);
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (chk_valid_o) begin
        if (lidx < exp_q.size()) chk("launch_vec", 64'(chk_vec_o), 64'(exp_q[lidx]));
        else chk("extra_launch", 64'(chk_valid_o), 64'd0);
        lidx++;
      end
      if (res_valid_o) begin
        chk("res_fail", 64'(res_fail_o), 64'(e_fail));
        chk("res_vec", 64'(res_vec_o), 64'(e_vec));
        chk("res_count", 64'(res_count_o), 64'(e_count));
      end
    end
  end

  task automatic run_sweep(input logic [NV-1:0] base, input logic [NV-1:0] mask, input int hold);
    int lim;
    build_model(base, mask);
    lidx   = 0;
    mon_en = 1'b1;
    @(negedge clk);
    base_i  = base;
    mask_i  = mask;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    lim = 0;
    while (!res_valid_o && lim < exp_q.size() + 20) begin
      @(negedge clk);
      lim++;
    end
    chk("result_valid", 64'(res_valid_o), 64'd1);
    chk("launches", 64'(lidx), 64'(e_launch));
    got_fail  = res_fail_o;
    got_vec   = res_vec_o;
    got_count = res_count_o;
    repeat (hold) @(negedge clk);
    res_ready_i = 1'b1;
    @(negedge clk);
    res_ready_i = 1'b0;
    chk("idle_after_ready", 64'(busy_o | res_valid_o), 64'd0);
    mon_en = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_chk_valid"}, 64'(chk_valid_o), 64'd0);
    chk({tag, "_chk_vec"}, 64'(chk_vec_o), 64'd0);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_res_valid"}, 64'(res_valid_o), 64'd0);
    chk({tag, "_res_fail"}, 64'(res_fail_o), 64'd0);
    chk({tag, "_res_vec"}, 64'(res_vec_o), 64'd0);
    chk({tag, "_res_count"}, 64'(res_count_o), 64'd0);
  endtask

  initial begin
    logic [63:0]   r;
    logic [NV-1:0] base, mask;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Full pass over three swept bits, result held for 5 cycles.
    bad_q.delete();
    run_sweep(49'h0, 49'h7, 5);
    chk("t1_fail", 64'(got_fail), 64'd0);
    chk("t1_count", 64'(got_count), 64'd8);
    chk("t1_vec", 64'(got_vec), 64'd0);

    bad_q.delete();
    bad_q.push_back(49'h7);
    run_sweep(49'h2, 49'h5, 1);
    chk("t2_fail", 64'(got_fail), 64'd1);
    chk("t2_vec", 64'(got_vec), 64'h7);
    chk("t2_count", 64'(got_count), 64'd4);

    bad_q.delete();
    bad_q.push_back(49'h3);
    bad_q.push_back(49'h5);
    run_sweep(49'h0, 49'hF, 0);
    chk("t3_vec", 64'(got_vec), 64'h3);
    chk("t3_count", 64'(got_count), 64'd4);

    bad_q.delete();
    bad_q.push_back(49'h1_0000_0000_0001);
    run_sweep(49'h1_0000_0000_0001, 49'h0, 2);
    chk("t4_fail", 64'(got_fail), 64'd1);
    chk("t4_count", 64'(got_count), 64'd1);
    chk("t4_launches", 64'(lidx), 64'd1);

    // Abort during the 10th launch.
    bad_q.delete();
    build_model(49'h0, 49'hFF);
    lidx   = 0;
    mon_en = 1'b1;
    @(negedge clk);
    mask_i  = 49'hFF;
    base_i  = 49'h0;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("abort_chk_valid", 64'(chk_valid_o), 64'd0);
    chk("abort_busy", 64'(busy_o), 64'd0);
    chk("abort_res_valid", 64'(res_valid_o), 64'd0);
    chk("abort_launches", 64'(lidx), 64'd10);
    repeat (3) @(negedge clk);
    chk("abort_no_result", 64'(res_valid_o | busy_o), 64'd0);
    mon_en = 1'b0;
    run_sweep(49'h0, 49'h1, 0);
    chk("abort_restart_count", 64'(got_count), 64'd2);

    // Asynchronous reset mid-sweep.
    build_model(49'h0, 49'hFF);
    lidx   = 0;
    mon_en = 1'b1;
    @(negedge clk);
    mask_i  = 49'hFF;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", 64'(busy_o), 64'd0);
    chk("post_rst_chk_valid", 64'(chk_valid_o), 64'd0);

    // Randomized sweeps.
    for (int it = 0; it < 14; it++) begin
      mask = '0;
      repeat ($urandom_range(0, 6)) mask[$urandom_range(0, NV - 1)] = 1'b1;
      r    = {$urandom, $urandom};
      base = r[NV-1:0];
      bad_q.delete();
      repeat ($urandom_range(0, 2)) begin
        r = {$urandom, $urandom};
        bad_q.push_back((base & ~mask) | (r[NV-1:0] & mask));
      end
      if ($urandom_range(0, 3) == 0) begin
        r = {$urandom, $urandom};
        bad_q.push_back(r[NV-1:0]);
      end
      run_sweep(base, mask, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
